// File: rtl/wb_shared_bus_scheduler_pkg.sv
// Shared definitions for the Wishbone interconnect: scheduler states,
// Wishbone data/select widths and the round-robin wrap helper.
package wb_shared_bus_scheduler_pkg;

  localparam int unsigned WB_DATA_WIDTH = 32;
  localparam int unsigned WB_SEL_WIDTH  = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1,
    ABORT   = 2'd2
  } sched_state_e;

  // Index reached by stepping 'offset' places past 'base', wrapping modulo 'modulus'.
  function automatic int unsigned rr_wrap(input int unsigned base,
                                          input int unsigned offset,
                                          input int unsigned modulus);
    return (base + offset) % modulus;
  endfunction

endpackage

// File: rtl/wb_shared_bus_scheduler_if.sv
// Controller-side and peripheral-side Wishbone signals of the shared bus
// scheduler. 'master' is the scheduler's view, 'slave' the surrounding fabric.
interface wb_shared_bus_scheduler_if
  import wb_shared_bus_scheduler_pkg::*;
#(
  parameter int unsigned NUM_CONTROLLERS = 4,
  parameter int unsigned ADDR_WIDTH      = 28
);

  // Controller side, packed per controller
  logic [NUM_CONTROLLERS-1:0]               ctrl_cyc;
  logic [NUM_CONTROLLERS-1:0]               ctrl_stb;
  logic [NUM_CONTROLLERS-1:0]               ctrl_we;
  logic [NUM_CONTROLLERS*ADDR_WIDTH-1:0]    ctrl_adr;
  logic [NUM_CONTROLLERS*WB_DATA_WIDTH-1:0] ctrl_dat_w;
  logic [NUM_CONTROLLERS*WB_SEL_WIDTH-1:0]  ctrl_sel;
  logic [NUM_CONTROLLERS-1:0]               ctrl_ack;
  logic [NUM_CONTROLLERS-1:0]               ctrl_err;
  logic [WB_DATA_WIDTH-1:0]                 ctrl_dat_r;

  // Shared peripheral bus
  logic                                     bus_cyc;
  logic                                     bus_stb;
  logic                                     bus_we;
  logic [ADDR_WIDTH-1:0]                    bus_adr;
  logic [WB_DATA_WIDTH-1:0]                 bus_dat_w;
  logic [WB_SEL_WIDTH-1:0]                  bus_sel;
  logic                                     bus_ack;
  logic                                     bus_err;
  logic [WB_DATA_WIDTH-1:0]                 bus_dat_r;

  // One-hot current owner
  logic [NUM_CONTROLLERS-1:0]               grant;

  modport master (
    input  ctrl_cyc, ctrl_stb, ctrl_we, ctrl_adr, ctrl_dat_w, ctrl_sel,
    input  bus_ack, bus_err, bus_dat_r,
    output ctrl_ack, ctrl_err, ctrl_dat_r,
    output bus_cyc, bus_stb, bus_we, bus_adr, bus_dat_w, bus_sel,
    output grant
  );

  modport slave (
    output ctrl_cyc, ctrl_stb, ctrl_we, ctrl_adr, ctrl_dat_w, ctrl_sel,
    output bus_ack, bus_err, bus_dat_r,
    input  ctrl_ack, ctrl_err, ctrl_dat_r,
    input  bus_cyc, bus_stb, bus_we, bus_adr, bus_dat_w, bus_sel,
    input  grant
  );

endinterface

// File: rtl/wb_shared_bus_scheduler_rr_next_picker.sv
// Combinational round-robin picker: returns the first active request found
// scanning upward from last_grant+1, wrapping modulo NUM_REQ.
module wb_shared_bus_scheduler_rr_next_picker
  import wb_shared_bus_scheduler_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] request,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [IDX_W-1:0]   next_idx,
  output logic               next_valid
);

  // Scan from the farthest candidate back to the nearest so the nearest hit wins
  always_comb begin
    next_idx   = '0;
    next_valid = 1'b0;
    for (int k = NUM_REQ; k > 0; k--) begin
      if (request[IDX_W'(rr_wrap(int'(last_grant), k, NUM_REQ))]) begin
        next_idx   = IDX_W'(rr_wrap(int'(last_grant), k, NUM_REQ));
        next_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_shared_bus_scheduler.sv
// Round-robin scheduler sharing one Wishbone classic bus between
// NUM_CONTROLLERS controllers. Ownership lasts a whole CYC; one dead cycle
// separates owners. Define WB_SCHED_TIMEOUT_EN to add a stall watchdog that
// aborts a transfer with ERR after TIMEOUT_CYCLES unanswered STB cycles.
module wb_shared_bus_scheduler
  import wb_shared_bus_scheduler_pkg::*;
#(
  parameter int unsigned NUM_CONTROLLERS = 4,
  parameter int unsigned ADDR_WIDTH      = 28,
  parameter int unsigned TIMEOUT_CYCLES  = 255
) (
  input logic                        clk,
  input logic                        rst,
  wb_shared_bus_scheduler_if.master  wb
);

  localparam int unsigned N     = NUM_CONTROLLERS;
  localparam int unsigned IDX_W = $clog2(NUM_CONTROLLERS);

  // Reject configurations the arbiter cannot represent
  if (NUM_CONTROLLERS < 2 || NUM_CONTROLLERS > 8) begin : g_bad_num_controllers
    $error("wb_shared_bus_scheduler: NUM_CONTROLLERS must be in 2..8");
  end
  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("wb_shared_bus_scheduler: TIMEOUT_CYCLES must be at least 1");
  end

  sched_state_e            state_q, state_d;
  logic [N-1:0]            grant_q, grant_d;
  logic [IDX_W-1:0]        gnt_idx_q, gnt_idx_d;
  logic [IDX_W-1:0]        last_grant_q, last_grant_d;

  logic [IDX_W-1:0]        pick_idx;
  logic                    pick_valid;

  logic                    owner_cyc;
  logic                    owner_stb;
  logic                    owner_we;
  logic [ADDR_WIDTH-1:0]   owner_adr;
  logic [WB_DATA_WIDTH-1:0] owner_dat_w;
  logic [WB_SEL_WIDTH-1:0] owner_sel;
  logic                    in_abort;

`ifdef WB_SCHED_TIMEOUT_EN
  localparam int unsigned STALL_W =
    ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [STALL_W-1:0]      stall_cnt_q, stall_cnt_d;

  assign in_abort = (state_q == ABORT);
`else
  assign in_abort = 1'b0;
`endif

  wb_shared_bus_scheduler_rr_next_picker #(
    .NUM_REQ (N),
    .IDX_W   (IDX_W)
  ) u_picker (
    .request    (wb.ctrl_cyc),
    .last_grant (last_grant_q),
    .next_idx   (pick_idx),
    .next_valid (pick_valid)
  );

  // AND-OR mux of the granted controller; yields zero when nothing is granted
  always_comb begin
    owner_cyc   = 1'b0;
    owner_stb   = 1'b0;
    owner_we    = 1'b0;
    owner_adr   = '0;
    owner_dat_w = '0;
    owner_sel   = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_q[i]) begin
        owner_cyc   = owner_cyc   | wb.ctrl_cyc[i];
        owner_stb   = owner_stb   | wb.ctrl_stb[i];
        owner_we    = owner_we    | wb.ctrl_we[i];
        owner_adr   = owner_adr   | wb.ctrl_adr[i*ADDR_WIDTH +: ADDR_WIDTH];
        owner_dat_w = owner_dat_w | wb.ctrl_dat_w[i*WB_DATA_WIDTH +: WB_DATA_WIDTH];
        owner_sel   = owner_sel   | wb.ctrl_sel[i*WB_SEL_WIDTH +: WB_SEL_WIDTH];
      end
    end
  end

  // Shared bus drive and response routing; ERR beats ACK, abort forces an idle bus
  assign wb.bus_cyc    = owner_cyc & ~in_abort;
  assign wb.bus_stb    = owner_stb & ~in_abort;
  assign wb.bus_we     = owner_we;
  assign wb.bus_adr    = owner_adr;
  assign wb.bus_dat_w  = owner_dat_w;
  assign wb.bus_sel    = owner_sel;
  assign wb.ctrl_ack   = grant_q & {N{wb.bus_ack & ~wb.bus_err & ~in_abort}};
  assign wb.ctrl_err   = in_abort ? grant_q : (grant_q & {N{wb.bus_err}});
  assign wb.ctrl_dat_r = wb.bus_dat_r;
  assign wb.grant      = grant_q;

  // Next-state: grant on any request, hold until owner drops CYC (or watchdog fires)
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    gnt_idx_d    = gnt_idx_q;
    last_grant_d = last_grant_q;
`ifdef WB_SCHED_TIMEOUT_EN
    stall_cnt_d  = '0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d   = N'(1) << pick_idx;
          gnt_idx_d = pick_idx;
          state_d   = GRANTED;
        end
      end
      GRANTED: begin
        if (!owner_cyc) begin
          grant_d      = '0;
          last_grant_d = gnt_idx_q;
          state_d      = IDLE;
        end
`ifdef WB_SCHED_TIMEOUT_EN
        else if (owner_stb && !wb.bus_ack && !wb.bus_err) begin
          if (stall_cnt_q == STALL_W'(TIMEOUT_CYCLES - 1)) begin
            state_d = ABORT;
          end else begin
            stall_cnt_d = stall_cnt_q + STALL_W'(1);
          end
        end
`endif
      end
`ifdef WB_SCHED_TIMEOUT_EN
      ABORT: begin
        grant_d      = '0;
        last_grant_d = gnt_idx_q;
        state_d      = IDLE;
      end
`endif
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State register; last_grant resets to N-1 so controller 0 is first in line
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      gnt_idx_q    <= '0;
      last_grant_q <= IDX_W'(N - 1);
`ifdef WB_SCHED_TIMEOUT_EN
      stall_cnt_q  <= '0;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      gnt_idx_q    <= gnt_idx_d;
      last_grant_q <= last_grant_d;
`ifdef WB_SCHED_TIMEOUT_EN
      stall_cnt_q  <= stall_cnt_d;
`endif
    end
  end

endmodule
